attn_sequencer: RTL and testbench
=================================

ATTN_SEQUENCER -- requirements
Module: attn_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2, sets clk cycles per ATTN_CLK half-period; legal range 1..15.
REQ-002 Parameter LE_WIDTH, default 2, sets the LE pulse width in clk cycles; legal range 1..15.
REQ-003 clk  input  1  system clock (CMCLK, 12.288 MHz); one clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 att1  input  5  host attenuation for chip 1, dB.
REQ-006 att2  input  5  host attenuation for chip 2, dB.
REQ-007 tx_att  input  5  attenuation applied to both chips while ptt is high.
REQ-008 ptt  input  1  transmit active, level.
REQ-009 force  input  1  one-cycle pulse; requests a resend of both chips.
REQ-010 ATTN_CLK  output  1  shared serial clock.
REQ-011 ATTN_DATA  output  1  shared serial data.
REQ-012 ATTN_LE  output  1  latch enable, chip 1.
REQ-013 ATTN_LE_2  output  1  latch enable, chip 2.
REQ-014 busy  output  1  high while a frame is in progress.
REQ-015 cur_att1, cur_att2  output  5 each  value last latched into each chip.

Function
REQ-016 Target per channel n SHALL be tgt_n = ptt ? tx_att : att_n.
REQ-017 In IDLE, pending flag pend_n SHALL be set when tgt_n != cur_att_n; force SHALL set both flags in any state, and a force arriving mid-frame SHALL be held until IDLE.
REQ-018 Arbitration SHALL be round-robin: with one flag set, that channel is served; with both set, the channel not served last is served; after reset, chip 1 is served first.
REQ-019 States SHALL be IDLE, LOAD, LOW, HIGH, GAP, LATCH, DONE.
REQ-020 LOAD (1 cycle): snapshot tgt_n into a 6-bit shift register {tgt_n, 1'b0}, clear pend_n, drive ATTN_DATA with bit 5, assert busy.
REQ-021 LOW (CLK_DIV cycles, ATTN_CLK=0, ATTN_DATA stable), then HIGH (CLK_DIV cycles, ATTN_CLK=1); repeat for 6 bits, MSB first; ATTN_DATA SHALL change only on entry to LOW.
REQ-022 GAP (CLK_DIV cycles, ATTN_CLK=0), then LATCH (LE_WIDTH cycles, the served channel's LE=1, the other LE=0).
REQ-023 DONE (1 cycle): both LEs=0, ATTN_DATA=0, busy=0, cur_att_n <= snapshot; next state IDLE.
REQ-024 busy SHALL be high for exactly 1+13*CLK_DIV+LE_WIDTH cycles per frame (29 cycles at defaults).
REQ-025 The snapshot SHALL be immune to input changes during a frame; a change made mid-frame SHALL be detected in IDLE and SHALL produce a new frame.
REQ-026 IDLE SHALL last at least 1 cycle between frames; only one LE SHALL be asserted at a time.
REQ-027 A ptt edge SHALL change tgt_n immediately; the resulting frames follow the normal arbitration and SHALL NOT abort a frame in progress.

Reset
REQ-028 While rst is high: ATTN_CLK, ATTN_DATA, ATTN_LE, ATTN_LE_2 and busy SHALL be 0; cur_att1 and cur_att2 SHALL be 0; state SHALL be IDLE; pend1 and pend2 SHALL be 1; the last-served pointer SHALL be set to chip 2.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no LE pulse; after release, both chips SHALL be rewritten, chip 1 first.

Configuration
REQ-030 Macro ATTN_PTT_OVERRIDE_EN: when defined, behaviour is per REQ-016; when undefined, tgt_n = att_n, and ptt and tx_att SHALL be ignored and need not drive any logic.

Verification
REQ-031 Release reset with att1=5, att2=10, defaults -> frame ATTN_DATA 001010 then ATTN_LE pulse; then frame 010100 then ATTN_LE_2 pulse; cur_att1=5, cur_att2=10; busy high 29 cycles per frame.
REQ-032 In IDLE, set att1=31 and att2=7 in the same cycle, with last-served=chip 2 -> chip 1 frame 111110 first, then chip 2 frame 001110, with at least 1 IDLE cycle between frames.
REQ-033 Change att1 from 3 to 20 during bit 2 of a chip 1 frame for 3 -> the in-flight frame shifts 000110 and cur_att1=3; the following frame shifts 101000 and cur_att1=20.
REQ-034 With macro defined, ptt=1 and tx_att=31 -> both chips written with 31; with ptt=0 -> att1 and att2 restored; with macro undefined, the same stimulus -> no frames.
REQ-035 Assert rst during the LATCH phase -> all outputs 0 asynchronously; after release, both chips are rewritten.
REQ-036 Pulse force once in IDLE with all values unchanged -> exactly two frames (chip 1, then chip 2); check ATTN_CLK high and low time of 2 cycles, i.e. 163 ns at 12.288 MHz, against the 30 ns minimum.

Source files
------------

// File: rtl/attn_sequencer.sv
// attn_sequencer: serial loader for two step attenuators sharing ATTN_CLK/ATTN_DATA, one frame per chip.
// Macro ATTN_PTT_OVERRIDE_EN: when defined, tx_att replaces both targets while ptt is high.
module attn_sequencer #(
  parameter int CLK_DIV  = 2,
  parameter int LE_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] att1,
  input  logic [4:0] att2,
  input  logic [4:0] tx_att,
  input  logic       ptt,
  input  logic       force_req,
  output logic       ATTN_CLK,
  output logic       ATTN_DATA,
  output logic       ATTN_LE,
  output logic       ATTN_LE_2,
  output logic       busy,
  output logic [4:0] cur_att1,
  output logic [4:0] cur_att2
);
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP, LATCH, DONE} state_t;
  localparam logic [3:0] DIV_M1 = 4'(CLK_DIV - 1);
  localparam logic [3:0] LE_M1  = 4'(LE_WIDTH - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] snap_q, snap_d, cur1_q, cur1_d, cur2_q, cur2_d;
  logic       ch_q, ch_d, last_q, last_d, pend1_q, pend1_d, pend2_q, pend2_d, frc_q, frc_d;
  logic       clk_q, clk_d, data_q, data_d, le1_q, le1_d, le2_q, le2_d, busy_q, busy_d;
  logic [4:0] tgt1, tgt2, tgt_sel;
  logic [5:0] frame;
  logic       p1, p2, sel2;
`ifdef ATTN_PTT_OVERRIDE_EN
  assign tgt1 = ptt ? tx_att : att1;
  assign tgt2 = ptt ? tx_att : att2;
`else
  logic unused_ptt;
  assign unused_ptt = ^{ptt, tx_att};
  assign tgt1 = att1;
  assign tgt2 = att2;
`endif
  // a force held from mid-frame joins the request set only once back in IDLE
  assign p1      = pend1_q | (tgt1 != cur1_q) | force_req | frc_q;
  assign p2      = pend2_q | (tgt2 != cur2_q) | force_req | frc_q;
  assign sel2    = p2 & (~p1 | ~last_q);
  assign tgt_sel = sel2 ? tgt2 : tgt1;
  assign frame   = {snap_q, 1'b0};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    snap_d  = snap_q;
    ch_d    = ch_q;
    last_d  = last_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    frc_d   = frc_q | force_req;
    cur1_d  = cur1_q;
    cur2_d  = cur2_q;
    clk_d   = clk_q;
    data_d  = data_q;
    le1_d   = le1_q;
    le2_d   = le2_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        frc_d   = 1'b0;
        pend1_d = p1 & sel2;
        pend2_d = p2 & ~sel2;
        if (p1 | p2) begin
          state_d = LOAD;
          ch_d    = sel2;
          last_d  = sel2;
          snap_d  = tgt_sel;
          data_d  = tgt_sel[4];
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = LOW;
        cnt_d   = '0;
        bit_d   = '0;
      end
      LOW: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          state_d = HIGH;
          clk_d   = 1'b1;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (bit_q == 3'd5) state_d = GAP;
          else begin
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            data_d  = frame[3'd4 - bit_q];
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          state_d = LATCH;
          le1_d   = ~ch_q;
          le2_d   = ch_q;
        end
      end
      LATCH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LE_M1) begin
          cnt_d   = '0;
          state_d = DONE;
          le1_d   = 1'b0;
          le2_d   = 1'b0;
          data_d  = 1'b0;
          busy_d  = 1'b0;
          cur1_d  = ch_q ? cur1_q : snap_q;
          cur2_d  = ch_q ? snap_q : cur2_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      snap_q  <= '0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      pend1_q <= 1'b1;
      pend2_q <= 1'b1;
      frc_q   <= 1'b0;
      cur1_q  <= '0;
      cur2_q  <= '0;
      clk_q   <= 1'b0;
      data_q  <= 1'b0;
      le1_q   <= 1'b0;
      le2_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      snap_q  <= snap_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      frc_q   <= frc_d;
      cur1_q  <= cur1_d;
      cur2_q  <= cur2_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      le1_q   <= le1_d;
      le2_q   <= le2_d;
      busy_q  <= busy_d;
    end
  end
  assign ATTN_CLK  = clk_q;
  assign ATTN_DATA = data_q;
  assign ATTN_LE   = le1_q;
  assign ATTN_LE_2 = le2_q;
  assign busy      = busy_q;
  assign cur_att1  = cur1_q;
  assign cur_att2  = cur2_q;
endmodule

// File: tb/tb_attn_sequencer.sv
// tb_attn_sequencer: random and directed frames checked against a round-robin frame-list model.
module tb_attn_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] att1 = '0, att2 = '0, tx_att = '0;
  logic       ptt = 1'b0, force_req = 1'b0;
  logic       ATTN_CLK, ATTN_DATA, ATTN_LE, ATTN_LE_2, busy;
  logic [4:0] cur_att1, cur_att2;
  attn_sequencer dut (
    .clk(clk), .rst(rst), .att1(att1), .att2(att2), .tx_att(tx_att), .ptt(ptt),
    .force_req(force_req), .ATTN_CLK(ATTN_CLK), .ATTN_DATA(ATTN_DATA), .ATTN_LE(ATTN_LE),
    .ATTN_LE_2(ATTN_LE_2), .busy(busy), .cur_att1(cur_att1), .cur_att2(cur_att2)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int fr_ch[$], fr_val[$], e_ch[$], e_val[$];
  int m_cur1, m_cur2;
  bit m_last, m_p1, m_p2;
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int tgt(input int a);
`ifdef ATTN_PTT_OVERRIDE_EN
    return ptt ? int'(tx_att) : a;
`else
    return a;
`endif
  endfunction
  task automatic model_reset();
    m_cur1 = 0; m_cur2 = 0; m_p1 = 1; m_p2 = 1; m_last = 1;
  endtask
  // expected frame list for stable inputs: serve requests, alternating when both want service
  task automatic predict();
    int t1, t2;
    bit p1, p2, s2;
    t1 = tgt(int'(att1));
    t2 = tgt(int'(att2));
    p1 = m_p1 || (t1 != m_cur1);
    p2 = m_p2 || (t2 != m_cur2);
    while (p1 || p2) begin
      s2 = p2 && (!p1 || m_last == 0);
      e_ch.push_back(int'(s2));
      e_val.push_back((s2 ? t2 : t1) * 2);
      if (s2) begin p2 = 0; m_cur2 = t2; end
      else begin p1 = 0; m_cur1 = t1; end
      m_last = s2;
    end
    m_p1 = 0; m_p2 = 0;
  endtask
  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 8 && n < 3000) begin
      @(negedge clk);
      n++;
      q = busy ? 0 : q + 1;
    end
    if (n >= 3000) chk("quiet_timeout", 1, 0);
  endtask
  task automatic check_frames();
    chk("n_frames", fr_ch.size(), e_ch.size());
    for (int i = 0; i < e_ch.size() && i < fr_ch.size(); i++) begin
      chk("frame_ch", fr_ch[i], e_ch[i]);
      chk("frame_val", fr_val[i], e_val[i]);
    end
    chk("cur_att1", int'(cur_att1), m_cur1);
    chk("cur_att2", int'(cur_att2), m_cur2);
    fr_ch.delete(); fr_val.delete(); e_ch.delete(); e_val.delete();
  endtask
  task automatic apply(input int a1, input int a2, input int p, input int tx, input bit f);
    @(posedge clk);
    #1;
    att1 = 5'(a1); att2 = 5'(a2); ptt = p[0]; tx_att = 5'(tx); force_req = f;
    @(posedge clk);
    #1 force_req = 1'b0;
    if (f) begin m_p1 = 1; m_p2 = 1; end
    predict();
    wait_quiet();
    check_frames();
  endtask
  // frame decoder on the serial pins, sampled mid-cycle
  initial begin
    logic [5:0] sh = '0;
    int nbits = 0, le_cnt = 0, busy_len = 0, hi_run = 0, lo_run = 0;
    bit prev_clk = 0, prev_busy = 0, seen_fall = 0, le_ch = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sh = '0; nbits = 0; le_cnt = 0; busy_len = 0; hi_run = 0; lo_run = 0; seen_fall = 0;
      end else begin
        if (busy) busy_len++;
        else if (prev_busy) begin
          chk("busy_len", busy_len, 29);
          busy_len = 0;
        end
        if (!busy) seen_fall = 0;
        if (ATTN_CLK) begin
          if (!prev_clk) begin
            if (seen_fall) chk("clk_low_time", lo_run, 2);
            sh = {sh[4:0], ATTN_DATA};
            nbits++;
          end
          hi_run = prev_clk ? hi_run + 1 : 1;
        end else begin
          if (prev_clk) begin
            chk("clk_high_time", hi_run, 2);
            seen_fall = 1;
          end
          lo_run = prev_clk ? 1 : lo_run + 1;
        end
        if (ATTN_LE && ATTN_LE_2) chk("le_exclusive", 1, 0);
        if (ATTN_LE || ATTN_LE_2) begin
          le_cnt++;
          le_ch = ATTN_LE_2;
        end else if (le_cnt > 0) begin
          chk("le_width", le_cnt, 2);
          chk("bit_count", nbits, 6);
          fr_ch.push_back(int'(le_ch));
          fr_val.push_back(int'(sh));
          le_cnt = 0;
          nbits = 0;
        end
      end
      prev_clk = ATTN_CLK;
      prev_busy = busy;
    end
  end
  initial begin
    int n;
    att1 = 5; att2 = 10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", int'({ATTN_CLK, ATTN_DATA, ATTN_LE, ATTN_LE_2, busy}), 0);
    chk("rst_cur", int'({cur_att1, cur_att2}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    predict();
    wait_quiet();
    check_frames();
    apply(31, 7, 0, 0, 0);
    apply(31, 7, 0, 0, 1);
    apply(4, 9, 0, 0, 0);
    apply(4, 9, 1, 31, 0);
    apply(4, 9, 0, 31, 0);
    // mid-frame change: in-flight frame keeps its snapshot
    apply(9, 9, 0, 0, 0);
    @(posedge clk);
    #1 att1 = 5'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 50);
    if (!busy) chk("busy_start_timeout", 0, 1);
    repeat (10) @(posedge clk);
    #1 att1 = 5'd20;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    chk("inflight_cur1", int'(cur_att1), 3);
    wait_quiet();
    e_ch = '{0, 0};
    e_val = '{6, 40};
    m_cur1 = 20; m_last = 0;
    check_frames();
    // reset during LATCH aborts the frame
    @(posedge clk);
    #1 force_req = 1'b1;
    @(posedge clk);
    #1 force_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ATTN_LE && n < 200);
    if (!ATTN_LE) chk("le_start_timeout", 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({ATTN_CLK, ATTN_DATA, ATTN_LE, ATTN_LE_2, busy}), 0);
    chk("async_rst_cur", int'({cur_att1, cur_att2}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fr_ch.delete(); fr_val.delete();
    model_reset();
    predict();
    wait_quiet();
    check_frames();
    for (int i = 0; i < 30; i++) begin
      int a1, a2, p, tx;
      bit f;
      a1 = $urandom_range(0, 1) ? int'(att1) : int'($urandom_range(0, 31));
      a2 = $urandom_range(0, 1) ? int'(att2) : int'($urandom_range(0, 31));
      p  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tx = int'($urandom_range(0, 31));
      f  = ($urandom_range(0, 3) == 0);
      apply(a1, a2, p, tx, f);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
